label_fetch: RTL and testbench
==============================

# label_fetch

Read-side initiator for the dual-port garbled-label memory. It accepts a gate's input-wire addresses from the evaluation core and polls the memory's per-address ready flags. It issues reads on ports 0/1 once each label is written, retrying on `stall_rd`, and returns both K-bit labels to the core over a valid/ready handshake. It sits between the gate scheduler and the label DPRAM, one instance per evaluation lane.

## Interface
Parameters:
- `S`, 13, wire-address width (DPRAM depth 2**S)
- `K`, 128, label width
- `TIMEOUT`, 4096, POLL cycles before `err_timeout` sets; 16-bit wait counter

Ports:
- `clk`  in  1  clock
- `rst`  in  1  reset, asynchronous, active-high
- `clr`  in  1  synchronous abort; returns block to IDLE, same cycle as DPRAM flag clear
- `req_valid`  in  1  fetch request from core
- `req_ready`  out  1  block can accept a request
- `req_addr_a`, `req_addr_b`  in  S  operand wire addresses
- `req_single`  in  1  only operand A needed; B treated as already fetched, `out_label_b` = 0
- `rd_req_0`, `rd_req_1`  out  1  DPRAM read requests
- `rd_addr_0`, `rd_addr_1`  out  S  DPRAM read addresses
- `rd_data_ready_0`, `rd_data_ready_1`  in  1  DPRAM flag for the current `rd_addr_x`, combinational
- `stall_rd`  in  1  DPRAM read ports taken by a deferred write this cycle
- `rd_data_0`, `rd_data_1`  in  K  DPRAM read data, valid the cycle after an accepted read
- `out_valid`  out  1  labels available
- `out_ready`  in  1  core consumes labels
- `out_label_a`, `out_label_b`  out  K  fetched labels
- `err_timeout`  out  1  sticky; a POLL phase exceeded TIMEOUT cycles

## Operation
- FSM states: IDLE, POLL, CAPT, OUT.
- **IDLE**
  - `req_ready`=1.
  - On `req_valid`: latch addresses into `addr_a_q`/`addr_b_q`, clear `got_a`, set `got_b`=`req_single`, clear the wait counter, go to POLL.
- **Address outputs:** `rd_addr_0`=`addr_a_q` and `rd_addr_1`=`addr_b_q` in every state, so the flags always reflect the pending operands.
- **POLL**
  - `rd_req_0` = !`got_a` & `rd_data_ready_0`.
  - `rd_req_1` = !`got_b` & `rd_data_ready_1`.
  - Both requests are combinational.
  - If any request is asserted and `stall_rd`=0: record `pend_a`/`pend_b` = the asserted requests, go to CAPT.
  - If `stall_rd`=1: the read is not accepted; stay in POLL and re-evaluate next cycle.
  - If no flag is set: stay in POLL.
  - The wait counter increments each POLL cycle and saturates at 16'hFFFF.
  - When the counter reaches TIMEOUT, `err_timeout` sets. POLL continues; there is no abort.
- **CAPT**
  - `rd_req_x`=0.
  - If `pend_a`: `label_a_q` <= `rd_data_0`, set `got_a`. If `pend_b`: `label_b_q` <= `rd_data_1`, set `got_b`.
  - If both got flags are set after the update, go to OUT; otherwise go back to POLL (one operand arrives before the other).
- **OUT**
  - `out_valid`=1 with labels held stable until `out_ready`; then go to IDLE.
  - `out_valid` must not drop without a handshake.
- **Abort:** `clr` in any state goes to IDLE, drops `out_valid`, clears got/pend and the wait counter, and clears `err_timeout`. `clr` takes priority over every transition in the same cycle.
- **Identical addresses:** `req_addr_a`==`req_addr_b` is legal; both ports read the same address.

## Timing
- Reset values:
  - State = IDLE; `req_ready`=1.
  - `rd_req_0`/`rd_req_1`=0; `rd_addr_0`/`rd_addr_1`=0.
  - `out_valid`=0; `out_label_a`/`out_label_b`=0.
  - `err_timeout`=0.
- Best-case latency, both flags set and no stall: request handshake at cycle 0, reads at cycle 1, capture at cycle 2, `out_valid` at cycle 3.
- Throughput: at most one request per 4 cycles (IDLE is a distinct state).
- Each `stall_rd` cycle adds one cycle of latency.
- A split arrival adds one POLL+CAPT pair per extra read.
- `rd_data_x` is sampled only in CAPT, exactly one cycle after an accepted read (DPRAM read latency 1).
- Reset mid-operation: async return to the reset values; a read already in flight is discarded.

## Structure
- Shared garbled-circuit package holds:
  - the state enum typedef (IDLE/POLL/CAPT/OUT)
  - default S/K constants, shared with the DPRAM
- Single module; no sub-module is natural (the FSM, two capture registers and the counter are all small).

## Test plan
- **Both flags set, no stall:** `req_addr_a`=5, `req_addr_b`=9, mem[5]=0xAA.., mem[9]=0xBB.. -> `rd_req_0`/`rd_req_1` high at cycle 1, `out_valid` at cycle 3 with labels 0xAA../0xBB..
- **Split arrival:** flag[9] set 10 cycles after the request -> A captured first, `rd_req_1` asserted the cycle flag[9] rises, `out_valid` 2 cycles later, label A unchanged.
- **Stall:** `stall_rd`=1 for 3 cycles while both flags are set -> read accepted on the 4th POLL cycle, `out_valid` at cycle 6.
- **Single operand:** `req_single`=1, addr_a=3 -> `rd_req_1` never asserts, `out_label_b`=0, `out_valid` at cycle 3.
- **Backpressure and abort:** `out_ready` low 5 cycles -> labels stable; `clr` pulse during POLL -> IDLE next cycle, `out_valid` never asserts.
- **Timeout:** TIMEOUT=8, flags never set -> `err_timeout` rises after 8 POLL cycles and stays set until `clr`; async `rst` mid-POLL -> all outputs at reset values immediately.

Source files
------------

// File: rtl/label_fetch_pkg.sv
// Shared garbled-circuit definitions: fetch FSM state encoding and the default
// label-memory geometry used by both the label DPRAM and its read initiators.
package label_fetch_pkg;

    // state | meaning
    // IDLE  | ready for a new gate request
    // POLL  | waiting for operand ready flags; issues reads when set
    // CAPT  | read data returning; latch labels for the reads just issued
    // OUT   | both labels held on out_label_*, waiting for out_ready
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_POLL = 2'd1,
        ST_CAPT = 2'd2,
        ST_OUT  = 2'd3
    } lf_state_e;

    localparam int GC_S       = 13;
    localparam int GC_K       = 128;
    localparam int GC_TIMEOUT = 4096;
    localparam int GC_CNT_W   = 16;

endpackage

// File: rtl/label_fetch.sv
// Read-side initiator for the garbled-label DPRAM. Latches a gate's two input
// wire addresses, polls the per-address ready flags, reads each label once it
// is written (retrying while the ports are stolen by a deferred write) and
// hands both labels to the evaluation core over valid/ready.
module label_fetch
    import label_fetch_pkg::*;
#(
    parameter int S       = GC_S,
    parameter int K       = GC_K,
    parameter int TIMEOUT = GC_TIMEOUT
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr_i,
    input  logic         req_valid_i,
    output logic         req_ready_o,
    input  logic [S-1:0] req_addr_a_i,
    input  logic [S-1:0] req_addr_b_i,
    input  logic         req_single_i,
    output logic         rd_req_0_o,
    output logic         rd_req_1_o,
    output logic [S-1:0] rd_addr_0_o,
    output logic [S-1:0] rd_addr_1_o,
    input  logic         rd_data_ready_0_i,
    input  logic         rd_data_ready_1_i,
    input  logic         stall_rd_i,
    input  logic [K-1:0] rd_data_0_i,
    input  logic [K-1:0] rd_data_1_i,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output logic [K-1:0] out_label_a_o,
    output logic [K-1:0] out_label_b_o,
    output logic         err_timeout_o
);

    // A TIMEOUT beyond the counter range can only be reached at saturation.
    localparam logic [GC_CNT_W-1:0] TO_CNT =
        (TIMEOUT > 65535) ? 16'hFFFF : GC_CNT_W'(TIMEOUT);

    lf_state_e             state_q;
    logic [S-1:0]          addr_a_q, addr_b_q;
    logic                  got_a_q, got_b_q;
    logic                  pend_a_q, pend_b_q;
    logic [K-1:0]          label_a_q, label_b_q;
    logic                  out_valid_q;
    logic                  err_q;
    logic [GC_CNT_W-1:0]   wait_cnt_q;

    logic [GC_CNT_W-1:0]   wait_cnt_d;
    logic                  got_a_d, got_b_d;
    logic                  rd_req_0, rd_req_1;
    logic                  rd_accept;

    // Read requests follow the live flags so a label is fetched the cycle it lands.
    always_comb begin
        rd_req_0   = (state_q == ST_POLL) && !got_a_q && rd_data_ready_0_i;
        rd_req_1   = (state_q == ST_POLL) && !got_b_q && rd_data_ready_1_i;
        rd_accept  = (rd_req_0 || rd_req_1) && !stall_rd_i;
        wait_cnt_d = (wait_cnt_q == 16'hFFFF) ? wait_cnt_q : wait_cnt_q + 16'd1;
        got_a_d    = got_a_q || pend_a_q;
        got_b_d    = got_b_q || pend_b_q;
    end

    // Fetch FSM with its operand bookkeeping, capture registers and wait counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            addr_a_q    <= '0;
            addr_b_q    <= '0;
            got_a_q     <= 1'b0;
            got_b_q     <= 1'b0;
            pend_a_q    <= 1'b0;
            pend_b_q    <= 1'b0;
            label_a_q   <= '0;
            label_b_q   <= '0;
            out_valid_q <= 1'b0;
            err_q       <= 1'b0;
            wait_cnt_q  <= '0;
        end else if (clr_i) begin
            // Abort lines up with the DPRAM flag clear; any read in flight is dropped.
            state_q     <= ST_IDLE;
            got_a_q     <= 1'b0;
            got_b_q     <= 1'b0;
            pend_a_q    <= 1'b0;
            pend_b_q    <= 1'b0;
            out_valid_q <= 1'b0;
            err_q       <= 1'b0;
            wait_cnt_q  <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req_valid_i) begin
                        addr_a_q   <= req_addr_a_i;
                        addr_b_q   <= req_addr_b_i;
                        got_a_q    <= 1'b0;
                        got_b_q    <= req_single_i;
                        pend_a_q   <= 1'b0;
                        pend_b_q   <= 1'b0;
                        // Cleared so a single-operand gate presents B as zero.
                        label_a_q  <= '0;
                        label_b_q  <= '0;
                        wait_cnt_q <= '0;
                        state_q    <= ST_POLL;
                    end
                end
                ST_POLL: begin
                    wait_cnt_q <= wait_cnt_d;
                    if (wait_cnt_d >= TO_CNT) begin
                        err_q <= 1'b1;
                    end
                    if (rd_accept) begin
                        pend_a_q <= rd_req_0;
                        pend_b_q <= rd_req_1;
                        state_q  <= ST_CAPT;
                    end
                end
                ST_CAPT: begin
                    if (pend_a_q) begin
                        label_a_q <= rd_data_0_i;
                    end
                    if (pend_b_q) begin
                        label_b_q <= rd_data_1_i;
                    end
                    got_a_q  <= got_a_d;
                    got_b_q  <= got_b_d;
                    pend_a_q <= 1'b0;
                    pend_b_q <= 1'b0;
                    if (got_a_d && got_b_d) begin
                        out_valid_q <= 1'b1;
                        state_q     <= ST_OUT;
                    end else begin
                        state_q <= ST_POLL;
                    end
                end
                ST_OUT: begin
                    if (out_ready_i) begin
                        out_valid_q <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign req_ready_o   = (state_q == ST_IDLE);
    assign rd_req_0_o    = rd_req_0;
    assign rd_req_1_o    = rd_req_1;
    assign rd_addr_0_o   = addr_a_q;
    assign rd_addr_1_o   = addr_b_q;
    assign out_valid_o   = out_valid_q;
    assign out_label_a_o = label_a_q;
    assign out_label_b_o = label_b_q;
    assign err_timeout_o = err_q;

endmodule

// File: tb/tb_label_fetch.sv
// Bench for label_fetch: behavioural DPRAM (flags + 1-cycle read latency),
// a fixed table of directed transactions, randomized transactions checked
// against a cycle-count reference model, and hand-written abort/timeout/reset
// sequences.
module tb_label_fetch;

    localparam int S  = 13;
    localparam int K  = 128;
    localparam int TO = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         clr = 1'b0;
    logic         req_valid = 1'b0;
    logic         req_ready;
    logic [S-1:0] req_addr_a = '0;
    logic [S-1:0] req_addr_b = '0;
    logic         req_single = 1'b0;
    logic         rd_req_0, rd_req_1;
    logic [S-1:0] rd_addr_0, rd_addr_1;
    logic         rd_data_ready_0, rd_data_ready_1;
    logic         stall_rd = 1'b0;
    logic [K-1:0] rd_data_0 = '0;
    logic [K-1:0] rd_data_1 = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [K-1:0] out_label_a, out_label_b;
    logic         err_timeout;

    logic [K-1:0] mem      [0:(1<<S)-1];
    logic         flag_mem [0:(1<<S)-1];

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [S-1:0] a;
        logic [S-1:0] b;
        logic         single;
        logic [K-1:0] da;
        logic [K-1:0] db;
        int           ta;
        int           tb;
        int           st_lo;
        int           st_n;
        int           bp;
        int           exp_ov;
    } txn_t;

    txn_t tbl [7];

    label_fetch #(.S(S), .K(K), .TIMEOUT(TO)) dut (
        .clk               (clk),
        .rst               (rst),
        .clr_i             (clr),
        .req_valid_i       (req_valid),
        .req_ready_o       (req_ready),
        .req_addr_a_i      (req_addr_a),
        .req_addr_b_i      (req_addr_b),
        .req_single_i      (req_single),
        .rd_req_0_o        (rd_req_0),
        .rd_req_1_o        (rd_req_1),
        .rd_addr_0_o       (rd_addr_0),
        .rd_addr_1_o       (rd_addr_1),
        .rd_data_ready_0_i (rd_data_ready_0),
        .rd_data_ready_1_i (rd_data_ready_1),
        .stall_rd_i        (stall_rd),
        .rd_data_0_i       (rd_data_0),
        .rd_data_1_i       (rd_data_1),
        .out_valid_o       (out_valid),
        .out_ready_i       (out_ready),
        .out_label_a_o     (out_label_a),
        .out_label_b_o     (out_label_b),
        .err_timeout_o     (err_timeout)
    );

    always #5 clk = ~clk;

    assign rd_data_ready_0 = flag_mem[rd_addr_0];
    assign rd_data_ready_1 = flag_mem[rd_addr_1];

    // DPRAM read ports: data one cycle after an accepted read, junk otherwise.
    always @(posedge clk) begin
        if (rd_req_0 && !stall_rd) rd_data_0 <= mem[rd_addr_0];
        else                       rd_data_0 <= {$urandom(), $urandom(), $urandom(), $urandom()};
        if (rd_req_1 && !stall_rd) rd_data_1 <= mem[rd_addr_1];
        else                       rd_data_1 <= {$urandom(), $urandom(), $urandom(), $urandom()};
    end

    task automatic check(input string nm, input logic [K-1:0] act, input logic [K-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic check_int(input string nm, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Reference: cycle at which out_valid first shows, counted from the request
    // handshake (cycle 0). A poll cycle with some needed flag up and no stall
    // reads those operands; the capture follows and the next poll (or output)
    // comes two cycles after the read.
    function automatic int model_ov(input txn_t t);
        bit need_a = 1'b1;
        bit need_b = !t.single;
        int c = 1;
        while (c < 200) begin
            bit ra = need_a && (c >= t.ta);
            bit rb = need_b && (c >= t.tb);
            bit st = (c >= t.st_lo) && (c < t.st_lo + t.st_n);
            if ((ra || rb) && !st) begin
                if (ra) need_a = 1'b0;
                if (rb) need_b = 1'b0;
                if (!need_a && !need_b) return c + 2;
                c += 2;
            end else begin
                c++;
            end
        end
        return -1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_txn(input txn_t t, input string nm);
        int           exp_ov;
        int           ov_cycle = -1;
        bit           single_viol = 1'b0;
        logic [K-1:0] exp_b;
        exp_ov = (t.exp_ov >= 0) ? t.exp_ov : model_ov(t);
        exp_b  = t.single ? '0 : t.db;
        mem[t.b] = t.db;
        mem[t.a] = t.da;
        flag_mem[t.a] = 1'b0;
        flag_mem[t.b] = 1'b0;
        out_ready  = 1'b0;
        req_valid  = 1'b1;
        req_addr_a = t.a;
        req_addr_b = t.b;
        req_single = t.single;
        #1;
        check({nm, " req_ready"}, req_ready, 1);
        tick();
        req_valid  = 1'b0;
        req_addr_a = S'($urandom());
        req_addr_b = S'($urandom());
        req_single = 1'($urandom());
        for (int c = 1; c < 60; c++) begin
            flag_mem[t.b] = (c >= t.tb);
            flag_mem[t.a] = (c >= t.ta);
            stall_rd = (c >= t.st_lo) && (c < t.st_lo + t.st_n);
            #1;
            if (t.single && rd_req_1) single_viol = 1'b1;
            if (out_valid) begin
                ov_cycle = c;
                break;
            end
            tick();
        end
        stall_rd = 1'b0;
        check_int({nm, " out_valid cycle"}, ov_cycle, exp_ov);
        check({nm, " rd_req_1 on single"}, single_viol, 0);
        if (ov_cycle < 0) begin
            clr = 1'b1;
            tick();
            clr = 1'b0;
            return;
        end
        check({nm, " label_a"}, out_label_a, t.da);
        check({nm, " label_b"}, out_label_b, exp_b);
        for (int i = 0; i < t.bp; i++) begin
            tick();
            check({nm, " hold valid"}, out_valid, 1);
            check({nm, " hold label_a"}, out_label_a, t.da);
            check({nm, " hold label_b"}, out_label_b, exp_b);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        #1;
        check({nm, " valid drop"}, out_valid, 0);
        check({nm, " back to idle"}, req_ready, 1);
    endtask

    initial begin
        txn_t r;
        for (int i = 0; i < (1 << S); i++) begin
            flag_mem[i] = 1'b0;
            mem[i] = '0;
        end

        //            a      b      sgl   da              db              ta tb lo n bp exp
        tbl[0] = '{13'd5,  13'd9,  1'b0, {16{8'hAA}}, {16{8'hBB}}, 1, 1,  1, 0, 0, 3};
        tbl[1] = '{13'd5,  13'd9,  1'b0, {16{8'hA1}}, {16{8'hB1}}, 1, 10, 1, 0, 0, 12};
        tbl[2] = '{13'd5,  13'd9,  1'b0, {16{8'hA2}}, {16{8'hB2}}, 1, 1,  1, 3, 0, 6};
        tbl[3] = '{13'd3,  13'd9,  1'b1, {16{8'hCC}}, {16{8'hDD}}, 1, 1,  1, 0, 0, 3};
        tbl[4] = '{13'd11, 13'd12, 1'b0, {16{8'h3C}}, {16{8'hC3}}, 1, 1,  1, 0, 5, 3};
        tbl[5] = '{13'd7,  13'd7,  1'b0, {16{8'hEE}}, {16{8'hEE}}, 1, 1,  1, 0, 0, 3};
        tbl[6] = '{13'd5,  13'd9,  1'b0, {16{8'h5A}}, {16{8'hA5}}, 2, 4,  2, 1, 0, 7};

        // Reset values while rst is held.
        #2;
        check("rst req_ready", req_ready, 1);
        check("rst rd_req_0", rd_req_0, 0);
        check("rst rd_req_1", rd_req_1, 0);
        check("rst rd_addr_0", rd_addr_0, 0);
        check("rst rd_addr_1", rd_addr_1, 0);
        check("rst out_valid", out_valid, 0);
        check("rst label_a", out_label_a, 0);
        check("rst label_b", out_label_b, 0);
        check("rst err", err_timeout, 0);
        tick();
        tick();
        rst = 1'b0;
        tick();

        for (int i = 0; i < 7; i++) begin
            run_txn(tbl[i], $sformatf("vec%0d", i));
            tick();
        end

        for (int i = 0; i < 40; i++) begin
            r.a      = S'($urandom_range(1, 4000));
            r.b      = ($urandom_range(0, 7) == 0) ? r.a : S'($urandom_range(4001, 8191));
            r.single = ($urandom_range(0, 3) == 0);
            r.da     = {$urandom(), $urandom(), $urandom(), $urandom()};
            r.db     = (r.a == r.b) ? r.da : {$urandom(), $urandom(), $urandom(), $urandom()};
            r.ta     = $urandom_range(1, 6);
            r.tb     = (r.a == r.b) ? r.ta : $urandom_range(1, 6);
            r.st_lo  = $urandom_range(1, 5);
            r.st_n   = $urandom_range(0, 3);
            r.bp     = $urandom_range(0, 3);
            r.exp_ov = -1;
            run_txn(r, $sformatf("rnd%0d", i));
            if ($urandom_range(0, 1) == 1) tick();
        end

        // Abort during POLL: back to IDLE next cycle, no output afterwards.
        flag_mem[20] = 1'b0;
        flag_mem[21] = 1'b0;
        req_valid = 1'b1; req_addr_a = 13'd20; req_addr_b = 13'd21; req_single = 1'b0;
        tick();
        req_valid = 1'b0;
        tick();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        #1;
        check("clr poll idle", req_ready, 1);
        flag_mem[20] = 1'b1;
        flag_mem[21] = 1'b1;
        begin
            bit seen_ov = 1'b0;
            bit seen_rd = 1'b0;
            for (int c = 0; c < 6; c++) begin
                tick();
                if (out_valid) seen_ov = 1'b1;
                if (rd_req_0 || rd_req_1) seen_rd = 1'b1;
            end
            check("clr poll no valid", seen_ov, 0);
            check("clr poll no read", seen_rd, 0);
        end

        // Abort while holding output.
        mem[50] = {16{8'h50}};
        mem[51] = {16{8'h51}};
        flag_mem[50] = 1'b1;
        flag_mem[51] = 1'b1;
        req_valid = 1'b1; req_addr_a = 13'd50; req_addr_b = 13'd51;
        tick();
        req_valid = 1'b0;
        tick();
        tick();
        #1;
        check("clr out valid before", out_valid, 1);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        #1;
        check("clr out valid after", out_valid, 0);
        check("clr out idle", req_ready, 1);

        // Timeout: err rises after TO poll cycles, sticky until clr.
        flag_mem[30] = 1'b0;
        flag_mem[31] = 1'b0;
        req_valid = 1'b1; req_addr_a = 13'd30; req_addr_b = 13'd31;
        tick();
        req_valid = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            #1;
            if (c == 1)  check("to err start", err_timeout, 0);
            if (c == TO) check("to err before", err_timeout, 0);
            if (c == TO + 1) check("to err set", err_timeout, 1);
            if (c == 12) begin
                check("to err sticky", err_timeout, 1);
                check("to still polling", req_ready, 0);
            end
            tick();
        end
        clr = 1'b1;
        tick();
        clr = 1'b0;
        #1;
        check("to err cleared", err_timeout, 0);
        check("to clr idle", req_ready, 1);

        // Async reset mid-POLL with a read request standing.
        flag_mem[40] = 1'b0;
        flag_mem[41] = 1'b0;
        req_valid = 1'b1; req_addr_a = 13'd40; req_addr_b = 13'd41;
        tick();
        req_valid = 1'b0;
        tick();
        stall_rd = 1'b1;
        flag_mem[40] = 1'b1;
        flag_mem[41] = 1'b1;
        #1;
        check("arst pre rd_req_0", rd_req_0, 1);
        #1;
        rst = 1'b1;
        #1;
        check("arst req_ready", req_ready, 1);
        check("arst rd_req_0", rd_req_0, 0);
        check("arst rd_req_1", rd_req_1, 0);
        check("arst rd_addr_0", rd_addr_0, 0);
        check("arst rd_addr_1", rd_addr_1, 0);
        check("arst out_valid", out_valid, 0);
        check("arst err", err_timeout, 0);
        stall_rd = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        run_txn(tbl[0], "post_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
